// File: rtl/robot_motor_driver.sv
// H-bridge gate driver: dead-time insertion, brake/coast, illegal-command flag.
// Optional duty soft-start ramp when MOTOR_SOFTSTART_EN is defined; otherwise full duty on DRIVE entry.
module robot_motor_driver #(
    parameter int PWM_BITS    = 8,
    parameter int DEAD_CYCLES = 4,
    parameter int RAMP_STEP   = 32,
    parameter int RAMP_DIV    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                Z1,
    input  logic                Z2,
    output logic                ha,
    output logic                la,
    output logic                hb,
    output logic                lb,
    output logic [PWM_BITS-1:0] duty,
    output logic [1:0]          state,
    output logic                fault
);

    typedef enum logic [1:0] {
        S_COAST = 2'd0,
        S_DEAD  = 2'd1,
        S_DRIVE = 2'd2,
        S_BRAKE = 2'd3
    } state_t;

    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DW-1:0]       DEAD_LOAD = DW'(DEAD_CYCLES - 1);
    localparam logic [DW-1:0]       DEAD_ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS-1:0] PWM_ONE   = {{(PWM_BITS-1){1'b0}}, 1'b1};

    if (DEAD_CYCLES < 1 || RAMP_DIV < 1 || RAMP_STEP < 0) begin : g_bad_params
    end

    state_t              state_q, state_d, target_q, target_d, cmd_s;
    logic [DW-1:0]       dead_cnt_q, dead_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
    logic                fault_q, fault_d;
    logic                ha_q, ha_d, la_q, la_d, hb_q, hb_d, lb_q, lb_d;

`ifdef MOTOR_SOFTSTART_EN
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RW-1:0]     RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [RW-1:0]     RAMP_ONE  = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [PWM_BITS:0] STEP_W    = (PWM_BITS+1)'(RAMP_STEP);
    logic [RW-1:0]     ramp_cnt_q, ramp_cnt_d;
    logic [PWM_BITS:0] duty_sum_s;
`endif

    // Command decode; 11 is illegal and treated as coast.
    always_comb begin
        fault_d = Z1 & Z2;
        if (en && Z1 && !Z2) begin
            cmd_s = S_DRIVE;
        end else if (en && !Z1 && Z2) begin
            cmd_s = S_BRAKE;
        end else begin
            cmd_s = S_COAST;
        end
    end

    // State transitions with dead-time on every switch-on.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        dead_cnt_d = dead_cnt_q;
        if (cmd_s == S_COAST) begin
            state_d    = S_COAST;
            target_d   = S_COAST;
            dead_cnt_d = {DW{1'b0}};
        end else if (state_q == S_DEAD) begin
            if (cmd_s != target_q) begin
                target_d   = cmd_s;
                dead_cnt_d = DEAD_LOAD;
            end else if (dead_cnt_q == {DW{1'b0}}) begin
                state_d = target_q;
            end else begin
                dead_cnt_d = dead_cnt_q - DEAD_ONE;
            end
        end else if (cmd_s != state_q) begin
            state_d    = S_DEAD;
            target_d   = cmd_s;
            dead_cnt_d = DEAD_LOAD;
        end else begin
            state_d = state_q;
        end
    end

    // PWM counter and duty; both restart on every DRIVE entry.
    always_comb begin
        pwm_cnt_d = {PWM_BITS{1'b0}};
        duty_d    = {PWM_BITS{1'b0}};
`ifdef MOTOR_SOFTSTART_EN
        ramp_cnt_d = {RW{1'b0}};
        duty_sum_s = {1'b0, duty_q} + STEP_W;
        if (state_d == S_DRIVE && state_q == S_DRIVE) begin
            pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? {PWM_BITS{1'b0}} : pwm_cnt_q + PWM_ONE;
            if (ramp_cnt_q == RAMP_LAST) begin
                ramp_cnt_d = {RW{1'b0}};
                duty_d     = (duty_sum_s > {1'b0, DUTY_MAX}) ? DUTY_MAX : duty_sum_s[PWM_BITS-1:0];
            end else begin
                ramp_cnt_d = ramp_cnt_q + RAMP_ONE;
                duty_d     = duty_q;
            end
        end else begin
            ramp_cnt_d = {RW{1'b0}};
        end
`else
        if (state_d == S_DRIVE && state_q == S_DRIVE) begin
            pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? {PWM_BITS{1'b0}} : pwm_cnt_q + PWM_ONE;
            duty_d    = duty_q;
        end else if (state_d == S_DRIVE) begin
            duty_d = DUTY_MAX;
        end else begin
            duty_d = {PWM_BITS{1'b0}};
        end
`endif
    end

    // Gate decode from the next state so gates and state update together.
    always_comb begin
        ha_d = 1'b0;
        la_d = 1'b0;
        hb_d = 1'b0;
        lb_d = 1'b0;
        case (state_d)
            S_BRAKE: begin
                la_d = 1'b1;
                lb_d = 1'b1;
            end
            S_DRIVE: begin
                lb_d = 1'b1;
                ha_d = (pwm_cnt_d < duty_d);
            end
            default: begin
                ha_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_COAST;
            target_q   <= S_COAST;
            dead_cnt_q <= {DW{1'b0}};
            pwm_cnt_q  <= {PWM_BITS{1'b0}};
            duty_q     <= {PWM_BITS{1'b0}};
            fault_q    <= 1'b0;
            ha_q       <= 1'b0;
            la_q       <= 1'b0;
            hb_q       <= 1'b0;
            lb_q       <= 1'b0;
`ifdef MOTOR_SOFTSTART_EN
            ramp_cnt_q <= {RW{1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            dead_cnt_q <= dead_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            duty_q     <= duty_d;
            fault_q    <= fault_d;
            ha_q       <= ha_d;
            la_q       <= la_d;
            hb_q       <= hb_d;
            lb_q       <= lb_d;
`ifdef MOTOR_SOFTSTART_EN
            ramp_cnt_q <= ramp_cnt_d;
`endif
        end
    end

    assign state = state_q;
    assign duty  = duty_q;
    assign fault = fault_q;
    assign ha    = ha_q;
    assign la    = la_q;
    assign hb    = hb_q;
    assign lb    = lb_q;

endmodule
